// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: owns the PC, keeps at most one instruction request in
// flight, and presents {pc, instr} to decode through a one-entry valid/ready
// register. Redirects from execute replace the PC and squash stale responses.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (trap misaligned fetch PCs).
module instr_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  localparam logic [63:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic        out_valid_q;
  logic [63:0] out_pc_q;
  logic [31:0] out_instr_q;

  logic out_free;
  logic pc_misalign;
  logic halted;
  logic req_acc;
  logic complete;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  logic halt_q;
  logic out_misalign_q;
  assign pc_misalign  = (pc_q[1:0] != 2'b00);
  assign halted       = halt_q;
  assign out_misalign = out_misalign_q;
`else
  assign pc_misalign  = 1'b0;
  assign halted       = 1'b0;
  assign out_misalign = 1'b0;
`endif

  // Output register can take a new entry when empty or draining this cycle.
  assign out_free   = !out_valid_q || out_ready;
  // Never put a request on the bus unless its response has somewhere to land.
  assign ireq_valid = (state_q == REQ) && out_free && !pc_misalign;
  assign ireq_addr  = pc_q;
  assign req_acc    = ireq_valid && iresp_addr_ok;
  assign complete   = ((state_q == REQ) && req_acc && iresp_data_ok) ||
                      ((state_q == WAIT) && iresp_data_ok);

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;

  // Fetch FSM, PC and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= 64'd0;
      out_instr_q <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_q         <= 1'b0;
      out_misalign_q <= 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (redirect_valid) begin
        // Redirect wins: buffered instruction is dropped even if accepted now.
        pc_q        <= redirect_pc;
        out_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        halt_q <= 1'b0;
`endif
        unique case (state_q)
          IDLE:    state_q <= REQ;
          REQ:     state_q <= (req_acc && !iresp_data_ok) ? DROP : REQ;
          WAIT:    state_q <= iresp_data_ok ? REQ : DROP;
          // A response landing now is the single stale one; nothing is left.
          DROP:    state_q <= iresp_data_ok ? REQ : DROP;
        endcase
      end else if (complete) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= pc_q;
        out_instr_q <= iresp_data;
        pc_q        <= pc_q + PC_STEP;
`ifdef FETCH_MISALIGN_CHECK_EN
        out_misalign_q <= 1'b0;
`endif
        state_q <= out_ready ? REQ : IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (out_free && !halted) begin
              state_q <= REQ;
            end
          end
          REQ: begin
            if (pc_misalign) begin
`ifdef FETCH_MISALIGN_CHECK_EN
              // Present a nop flagged misaligned and park until redirected.
              if (out_free) begin
                out_valid_q    <= 1'b1;
                out_pc_q       <= pc_q;
                out_instr_q    <= NOP_INSTR;
                out_misalign_q <= 1'b1;
                halt_q         <= 1'b1;
                state_q        <= IDLE;
              end
`endif
            end else if (req_acc) begin
              state_q <= WAIT;
            end
          end
          WAIT: state_q <= WAIT;
          DROP: begin
            if (iresp_data_ok) begin
              state_q <= out_free ? REQ : IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
